// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one data-memory port between the instruction-fetch unit (IFU) and
//   the load/store unit (LSU). Only one access is in flight at a time. Each
//   access passes through three states:
//     IDLE - pick a requester and capture its request fields
//     REQ  - present the captured request to memory until memory accepts it
//     WAIT - wait for the memory response, guarded by a timeout counter
//   When both units are requesting, the grant alternates between them
//   (round-robin).
//
// Ports
//   clk, rst                    clock; asynchronous reset, active-low
//   ifu_req_valid/ready, ifu_addr
//                               IFU request channel (ready is combinational)
//   ifu_rsp_valid/data          IFU response (one-cycle pulse)
//   lsu_req_valid/ready, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask
//                               LSU request channel (ready is combinational)
//   lsu_rsp_valid/data          LSU response (one-cycle pulse; data is 0 for stores)
//   mem_req_valid/ready, mem_wen, mem_addr, mem_wdata, mem_wmask
//                               request to memory, driven from the captured fields
//   mem_rsp_valid/data          memory response (only looked at in WAIT)
//   err                         sticky timeout flag
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_wen,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                err
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e              state_q, state_d;
  logic                last_lsu_q, last_lsu_d;    // 1: the LSU held the last grant
  logic                owner_lsu_q, owner_lsu_d;  // 1: the LSU owns the in-flight access
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic [DATA_W-1:0]   ifu_rsp_data_q, ifu_rsp_data_d;
  logic                lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic [DATA_W-1:0]   lsu_rsp_data_q, lsu_rsp_data_d;
  logic                err_q, err_d;

  logic grant_ifu, grant_lsu;

  // When both units request, grant the one that did not win last time.
  assign grant_ifu = ifu_req_valid & (~lsu_req_valid | last_lsu_q);
  assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_lsu_q);

  always_comb begin
    state_d         = state_q;
    last_lsu_d      = last_lsu_q;
    owner_lsu_d     = owner_lsu_q;
    wen_d           = wen_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    cnt_d           = cnt_q;
    ifu_rsp_valid_d = 1'b0;
    ifu_rsp_data_d  = ifu_rsp_data_q;
    lsu_rsp_valid_d = 1'b0;
    lsu_rsp_data_d  = lsu_rsp_data_q;
    err_d           = err_q;
    ifu_req_ready   = 1'b0;
    lsu_req_ready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The ready signals are gated with rst so that they drop as soon as
        // reset is asserted, even though the state register already reads IDLE.
        ifu_req_ready = grant_ifu & rst;
        lsu_req_ready = grant_lsu & rst;
        if (grant_ifu) begin
          addr_d      = ifu_addr;
          wen_d       = 1'b0;
          wdata_d     = '0;
          wmask_d     = '0;
          owner_lsu_d = 1'b0;
          last_lsu_d  = 1'b0;
          state_d     = S_REQ;
        end else if (grant_lsu) begin
          addr_d      = lsu_addr;
          wen_d       = lsu_wen;
          wdata_d     = lsu_wdata;
          wmask_d     = lsu_wmask;
          owner_lsu_d = 1'b1;
          last_lsu_d  = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rsp_valid) begin
          if (owner_lsu_q) begin
            lsu_rsp_valid_d = 1'b1;
            lsu_rsp_data_d  = wen_q ? '0 : mem_rsp_data;
          end else begin
            ifu_rsp_valid_d = 1'b1;
            ifu_rsp_data_d  = mem_rsp_data;
          end
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Abort: the response pulse is registered in the same way as a
          // normal response and carries zero data.
          err_d = 1'b1;
          if (owner_lsu_q) begin
            lsu_rsp_valid_d = 1'b1;
            lsu_rsp_data_d  = '0;
          end else begin
            ifu_rsp_valid_d = 1'b1;
            ifu_rsp_data_d  = '0;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      last_lsu_q      <= 1'b1;
      owner_lsu_q     <= 1'b0;
      wen_q           <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      cnt_q           <= '0;
      ifu_rsp_valid_q <= 1'b0;
      ifu_rsp_data_q  <= '0;
      lsu_rsp_valid_q <= 1'b0;
      lsu_rsp_data_q  <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_lsu_q      <= last_lsu_d;
      owner_lsu_q     <= owner_lsu_d;
      wen_q           <= wen_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wmask_q         <= wmask_d;
      cnt_q           <= cnt_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      ifu_rsp_data_q  <= ifu_rsp_data_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      lsu_rsp_data_q  <= lsu_rsp_data_d;
      err_q           <= err_d;
    end
  end

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_wen       = wen_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_rsp_valid = ifu_rsp_valid_q;
  assign ifu_rsp_data  = ifu_rsp_data_q;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign lsu_rsp_data  = lsu_rsp_data_q;
  assign err           = err_q;

endmodule
